// File: rtl/hash_host_ctrl.sv
// -----------------------------------------------------------------------------
// hash_host_ctrl
//
// Host-side controller for the Ascon hash core. It accepts one y-bit message
// over a valid/ready slave port and presents it on hash_msg. It pulses
// hash_start and waits for the core's ready to fall and then rise again. It
// then captures the l-bit digest and streams it out MSB-first as W-bit beats
// on a valid/ready master port.
//
// Optional feature macro: HASH_TIMEOUT_EN
//   Adds a watchdog that aborts a stuck core wait after TIMEOUT cycles. The
//   abort goes through a one-cycle ERR state and sets a sticky timeout_err
//   flag, which the next accepted message clears. Without the macro the wait
//   is unbounded and timeout_err is tied low.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous reset, active low
//   s_msg        : message to hash (y bits)
//   s_valid      : s_msg valid
//   s_ready      : controller idle, can accept a message
//   hash_msg     : message to core, stable from START until back in IDLE
//   hash_start   : one-cycle start pulse to core
//   hash_ready   : core ready level
//   hash_text    : core digest (l bits)
//   m_data       : digest beat (W bits), beat 0 = MSBs
//   m_valid      : beat valid
//   m_last       : final beat of the digest
//   m_ready      : downstream accepts beat
//   busy         : high in every state except IDLE
//   timeout_err  : sticky watchdog expiry flag
// -----------------------------------------------------------------------------
module hash_host_ctrl #(
    parameter int y       = 40,
    parameter int l       = 256,
    parameter int W       = 32,
    parameter int TIMEOUT = 4095
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [y-1:0] s_msg,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [y-1:0] hash_msg,
    output logic         hash_start,
    input  logic         hash_ready,
    input  logic [l-1:0] hash_text,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    output logic         m_last,
    input  logic         m_ready,
    output logic         busy,
    output logic         timeout_err
);

    localparam int NBEATS = l / W;
    localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

    // Elaboration-time parameter sanity checks.
    if ((l % W) != 0) begin : g_bad_beat_width
        $error("hash_host_ctrl: l must be a multiple of W");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("hash_host_ctrl: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_STREAM
`ifdef HASH_TIMEOUT_EN
        , ST_ERR
`endif
    } state_t;

    state_t         r_state;
    logic           r_s_ready;
    logic           r_hash_start;
    logic           r_m_valid;
    logic           r_m_last;
    logic           r_busy;
    logic [y-1:0]   r_hash_msg;
    logic [l-1:0]   r_digest;
    logic [BCW-1:0] r_beat;
    logic [l-1:0]   w_digest_sh;
    logic           w_accept;

    assign w_accept = (r_state == ST_IDLE) && s_valid;

`ifdef HASH_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] r_wdog;
    logic           r_timeout_err;
    logic           w_to_err;

    // A core ready seen in WAIT_HI wins over a simultaneous expiry.
    assign w_to_err = (r_wdog == WDW'(TIMEOUT)) &&
                      ((r_state == ST_WAIT_LO) ||
                       ((r_state == ST_WAIT_HI) && !hash_ready));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wdog        <= '0;
                r_timeout_err <= 1'b0;
            end else if ((r_state == ST_WAIT_LO) || (r_state == ST_WAIT_HI)) begin
                r_wdog <= r_wdog + WDW'(1);
            end
            if (w_to_err) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_s_ready    <= 1'b1;
            r_hash_start <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_busy       <= 1'b0;
            r_hash_msg   <= '0;
            r_digest     <= '0;
            r_beat       <= '0;
        end else begin
            r_hash_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hash_msg   <= s_msg;
                        r_hash_start <= 1'b1;
                        r_s_ready    <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT_LO;
                end
                // Ignore a ready level left high by the previous operation.
                ST_WAIT_LO: begin
`ifdef HASH_TIMEOUT_EN
                    if (w_to_err) begin
                        r_state <= ST_ERR;
                    end else
`endif
                    if (!hash_ready) begin
                        r_state <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (hash_ready) begin
                        r_digest  <= hash_text;
                        r_beat    <= '0;
                        r_m_valid <= 1'b1;
                        r_m_last  <= (NBEATS == 1);
                        r_state   <= ST_STREAM;
                    end
`ifdef HASH_TIMEOUT_EN
                    else if (w_to_err) begin
                        r_state <= ST_ERR;
                    end
`endif
                end
                ST_STREAM: begin
                    if (m_ready) begin
                        if (r_beat == LAST_BEAT) begin
                            r_m_valid <= 1'b0;
                            r_m_last  <= 1'b0;
                            r_busy    <= 1'b0;
                            r_s_ready <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_beat   <= r_beat + BCW'(1);
                            r_m_last <= ((r_beat + BCW'(1)) == LAST_BEAT);
                        end
                    end
                end
`ifdef HASH_TIMEOUT_EN
                ST_ERR: begin
                    r_busy    <= 1'b0;
                    r_s_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
`endif
                default: begin
                    r_m_valid <= 1'b0;
                    r_m_last  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_s_ready <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Beat i sits at the top of the digest once shifted left by W*i.
    assign w_digest_sh = r_digest << (W * int'(r_beat));
    assign m_data      = w_digest_sh[l-1 -: W];

    assign s_ready    = r_s_ready;
    assign hash_msg   = r_hash_msg;
    assign hash_start = r_hash_start;
    assign m_valid    = r_m_valid;
    assign m_last     = r_m_last;
    assign busy       = r_busy;

endmodule

// File: doc/hash_host_ctrl.md
# hash_host_ctrl

Host-side controller for the Ascon hash datapath: the initiator that drives the core's `message`/`start` inputs and the reader that consumes its `ready`/`hash_text` outputs. It accepts one message word per operation over a valid/ready slave port, launches the hash core (plain, threshold-implemented or triple-redundant fault-countermeasure wrapper), waits for completion, captures the l-bit digest and streams it out MSB-first as W-bit beats on a valid/ready master port. It sits between the system bus adapter and the hash core instance.

## Interface
- `y`, 40: message width; must match the core's `y`.
- `l`, 256: digest width; must match the core's `l`.
- `W`, 32: output beat width; `l % W == 0` required.
- `TIMEOUT`, 4095: watchdog limit in cycles; used only with `HASH_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: reset, synchronous, active-low.
- `s_msg` in y: message to hash.
- `s_valid` in 1: `s_msg` valid.
- `s_ready` out 1: controller can accept a message.
- `hash_msg` out y: to core `message`.
- `hash_start` out 1: to core `start`.
- `hash_ready` in 1: from core `ready`.
- `hash_text` in l: from core `hash_text`.
- `m_data` out W: digest beat.
- `m_valid` out 1: beat valid.
- `m_last` out 1: final beat of digest.
- `m_ready` in 1: downstream accepts beat.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: watchdog expiry flag.

## Operation
- States: IDLE, START, WAIT_LO, WAIT_HI, STREAM, plus ERR with `HASH_TIMEOUT_EN`.
- IDLE: `s_ready`=1. On `s_valid & s_ready`: latch `s_msg` into `hash_msg`, go START.
- START: `hash_start`=1 for exactly this cycle. Go WAIT_LO.
- WAIT_LO: wait for `hash_ready`=0. This rejects a `ready` level left high by the previous operation. Then go WAIT_HI.
- WAIT_HI: on `hash_ready`=1, latch `hash_text` into the digest register. Clear beat counter. Go STREAM.
- STREAM: `m_valid`=1. `m_data` = digest[l-1-W*i -: W] for beat i (beat 0 = MSBs). `m_last`=1 when i = l/W-1.
  - On `m_valid & m_ready`: i increments.
  - After the last beat transfers: go IDLE.
- `hash_msg` stays stable from START until return to IDLE. It changes only on acceptance.
- The beat counter width is clog2(l/W). It never wraps, because STREAM exits at the last beat.
- The digest register is unaffected by `hash_text` changes after capture.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE; `hash_msg`, digest register, beat counter and watchdog cleared.
  - All outputs 0 except `s_ready`=1 (derived from IDLE).
- Reset asserted mid-operation aborts immediately.
  - `m_valid`/`hash_start` are 0 the cycle after the reset edge.
  - Any partial digest stream is discarded.
- Acceptance at edge t: `hash_start`=1 during cycle t+1; `busy`=1 from t+1.
- `hash_ready` observed high in WAIT_HI at edge c: `m_valid`=1 with beat 0 from cycle c+1.
- Zero-wait downstream (`m_ready` tied 1): l/W beats on consecutive cycles, then `s_ready`=1 the cycle after the last beat.
- `m_data`/`m_last` hold while `m_valid & !m_ready`.
- `s_valid` outside IDLE is ignored (not accepted, not queued).

## Configuration
- `HASH_TIMEOUT_EN` defined:
  - A watchdog counter clears on entering START and increments each cycle in WAIT_LO/WAIT_HI.
  - Reaching `TIMEOUT` goes to ERR. ERR lasts one cycle, then IDLE.
  - `timeout_err` goes 1 on entering ERR. It is sticky until the next accepted message clears it.
  - No digest beats are emitted for a timed-out operation.
- `HASH_TIMEOUT_EN` undefined: no counter and no ERR state. WAIT states wait indefinitely. `timeout_err` is tied 0.

## Test plan
- Basic run (l=256, W=32): accept `s_msg`=0x0123456789, core model raises ready after 70 cycles with digest D -> one-cycle `hash_start`, 8 beats D[255:224]…D[31:0], `m_last` on beat 7 only, `s_ready`=1 next cycle.
- Stale ready: core `hash_ready` still 1 at acceptance, drops 3 cycles later, rises at 60 -> capture only at the second rise; no beats earlier.
- Backpressure: `m_ready` toggles 1,0,0,1,… -> each beat held stable while stalled; exactly 8 transfers, values unchanged.
- Busy rejection: `s_valid` held high with a new message during STREAM -> not accepted until IDLE; `hash_msg` unchanged until then.
- Reset mid-stream: `rst`=0 after beat 3 -> next cycle `m_valid`=0, `busy`=0, `s_ready`=1, `hash_msg`=0.
- With `HASH_TIMEOUT_EN`, `TIMEOUT`=16, core never readies -> `timeout_err`=1 17–18 cycles after start, no `m_valid`, returns IDLE. Next acceptance clears the flag.
